// File: rtl/store_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | store_buffer_if : pipeline-side store/load request and data-memory |
// | port bundle for store_buffer.                                      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface store_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                     st_valid;
  logic [XLEN-1:0]          st_addr;
  logic [XLEN-1:0]          st_data;
  logic [2:0]               st_funct3;
  logic                     st_ready;
  logic                     ld_valid;
  logic [XLEN-1:0]          ld_addr;
  logic [2:0]               ld_funct3;
  logic                     ld_stall;
  logic                     mem_WE;
  logic [XLEN-1:0]          mem_A;
  logic [XLEN-1:0]          mem_WD;
  logic [2:0]               mem_AddressingControl;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output st_valid, st_addr, st_data, st_funct3,
    output ld_valid, ld_addr, ld_funct3,
    input  st_ready, ld_stall,
    input  mem_WE, mem_A, mem_WD, mem_AddressingControl,
    input  empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_funct3,
    input  ld_valid, ld_addr, ld_funct3,
    output st_ready, ld_stall,
    output mem_WE, mem_A, mem_WD, mem_AddressingControl,
    output empty, count
  );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | store_buffer : circular FIFO of pending stores sharing one data-    |
// | memory port with loads; loads win unless they overlap a store.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module store_buffer #(
  parameter int XLEN          = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DEPTH         = 4
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  sb
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam int C_AW    = ADDRESS_WIDTH;

  typedef logic [C_PTR_W-1:0] ptr_t;
  typedef logic [C_CNT_W-1:0] cnt_t;

  logic [XLEN-1:0] addr_q   [DEPTH];
  logic [XLEN-1:0] addr_d   [DEPTH];
  logic [XLEN-1:0] data_q   [DEPTH];
  logic [XLEN-1:0] data_d   [DEPTH];
  logic [2:0]      funct3_q [DEPTH];
  logic [2:0]      funct3_d [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic w_hit;
  logic w_ld_stall;
  logic w_ld_grant;
  logic w_pop;
  logic w_push;
  logic w_st_ready;
  logic w_st_type_ok;

  function automatic logic [2:0] size_of(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Two wrapped ranges intersect iff the start of one lies inside the other.
  function automatic logic ranges_overlap(input logic [C_AW-1:0] a, input logic [2:0] a_sz,
                                          input logic [C_AW-1:0] b, input logic [2:0] b_sz);
    logic [C_AW-1:0] b_minus_a;
    logic [C_AW-1:0] a_minus_b;
    b_minus_a = b - a;
    a_minus_b = a - b;
    return (b_minus_a < {{(C_AW-3){1'b0}}, a_sz}) ||
           (a_minus_b < {{(C_AW-3){1'b0}}, b_sz});
  endfunction

  always_comb begin : p_hit
    ptr_t off;
    off   = '0;
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = ptr_t'(i) - head_q;
      if (({1'b0, off} < count_q) &&
          ranges_overlap(sb.ld_addr[C_AW-1:0], size_of(sb.ld_funct3),
                         addr_q[i][C_AW-1:0], size_of(funct3_q[i]))) begin
        w_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_ld_stall   = sb.ld_valid & w_hit;
    w_ld_grant   = sb.ld_valid & ~w_ld_stall;
    w_pop        = ~w_ld_grant & (count_q != '0);
    w_st_ready   = (count_q < cnt_t'(DEPTH));
    w_st_type_ok = ~sb.st_funct3[2] & (sb.st_funct3[1:0] != 2'b11);
    w_push       = sb.st_valid & w_st_ready & w_st_type_ok;

    sb.st_ready              = w_st_ready;
    sb.ld_stall              = w_ld_stall;
    sb.empty                 = (count_q == '0);
    sb.count                 = count_q;
    sb.mem_WE                = 1'b0;
    sb.mem_A                 = '0;
    sb.mem_WD                = '0;
    sb.mem_AddressingControl = 3'b000;
    if (w_ld_grant) begin
      sb.mem_A                 = sb.ld_addr;
      sb.mem_AddressingControl = sb.ld_funct3;
    end else if (w_pop) begin
      sb.mem_WE                = 1'b1;
      sb.mem_A                 = addr_q[head_q];
      sb.mem_WD                = data_q[head_q];
      sb.mem_AddressingControl = funct3_q[head_q];
    end
  end

  always_comb begin
    head_d   = head_q + ptr_t'(w_pop);
    tail_d   = tail_q + ptr_t'(w_push);
    count_d  = count_q + cnt_t'(w_push) - cnt_t'(w_pop);
    addr_d   = addr_q;
    data_d   = data_q;
    funct3_d = funct3_q;
    if (w_push) begin
      addr_d[tail_q]   = sb.st_addr;
      data_d[tail_q]   = sb.st_data;
      funct3_d[tail_q] = sb.st_funct3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is validated by count, so it carries no reset.
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    data_q   <= data_d;
    funct3_q <= funct3_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_store_buffer : directed scenarios plus random traffic checked   |
// | against a queue-based model of the store buffer.                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_store_buffer;

  localparam int XLEN  = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  store_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) sb_if ();

  store_buffer #(.XLEN(XLEN), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Byte-by-byte comparison of the two footprints in the decoded address space.
  function automatic bit touches(input logic [31:0] la, input logic [2:0] lf,
                                 input logic [31:0] sa, input logic [2:0] sf);
    longint unsigned m;
    longint unsigned x;
    longint unsigned y;
    m = longint'(1) << AW;
    for (int k = 0; k < nbytes(lf); k++) begin
      for (int j = 0; j < nbytes(sf); j++) begin
        x = (longint'(la) + k) % m;
        y = (longint'(sa) + j) % m;
        if (x == y) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit exp_stall();
    if (!sb_if.ld_valid) return 1'b0;
    foreach (q[i]) if (touches(sb_if.ld_addr, sb_if.ld_funct3, q[i].a, q[i].f)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit r, input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [2:0] sf, input bit lv, input logic [31:0] la,
                      input logic [2:0] lf);
    @(negedge clk);
    rst             = r;
    sb_if.st_valid  = sv;
    sb_if.st_addr   = sa;
    sb_if.st_data   = sd;
    sb_if.st_funct3 = sf;
    sb_if.ld_valid  = lv;
    sb_if.ld_addr   = la;
    sb_if.ld_funct3 = lf;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 3'b000);
  endtask

  task automatic model_check();
    bit          stall;
    bit          grant;
    logic [31:0] e_a;
    logic [31:0] e_wd;
    logic [2:0]  e_ac;
    bit          e_we;
    stall = exp_stall();
    grant = sb_if.ld_valid && !stall;
    e_a = 32'h0; e_wd = 32'h0; e_ac = 3'b000; e_we = 1'b0;
    if (grant) begin
      e_a  = sb_if.ld_addr;
      e_ac = sb_if.ld_funct3;
    end else if (q.size() > 0) begin
      e_we = 1'b1;
      e_a  = q[0].a;
      e_wd = q[0].d;
      e_ac = q[0].f;
    end
    chk("count",    64'(sb_if.count), 64'(q.size()));
    chk("empty",    64'(sb_if.empty), 64'(q.size() == 0));
    chk("st_ready", 64'(sb_if.st_ready), 64'(q.size() < DEPTH));
    chk("ld_stall", 64'(sb_if.ld_stall), 64'(stall));
    chk("mem_WE",   64'(sb_if.mem_WE), 64'(e_we));
    chk("mem_A",    64'(sb_if.mem_A), 64'(e_a));
    chk("mem_WD",   64'(sb_if.mem_WD), 64'(e_wd));
    chk("mem_AC",   64'(sb_if.mem_AddressingControl), 64'(e_ac));
  endtask

  task automatic tick();
    bit grant;
    bit can_take;
    @(posedge clk);
    grant    = sb_if.ld_valid && !exp_stall();
    can_take = q.size() < DEPTH;
    if (rst) begin
      q.delete();
    end else begin
      if (!grant && q.size() > 0) void'(q.pop_front());
      if (sb_if.st_valid && can_take && (sb_if.st_funct3 inside {3'b000, 3'b001, 3'b010}))
        q.push_back('{a: sb_if.st_addr, d: sb_if.st_data, f: sb_if.st_funct3});
    end
  endtask

  initial begin
    logic [31:0] bases [3];
    logic [2:0]  lds   [5];
    logic [31:0] sa, la;
    logic [2:0]  sf, lf;
    bases = '{32'h0000_0100, 32'h0001_FFFC, 32'h0000_0200};
    lds   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Reset state
    step(1'b1, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 3'b000);
    tick();
    idle();
    model_check();
    chk("rst_count", 64'(sb_if.count), 64'd0);
    chk("rst_ready", 64'(sb_if.st_ready), 64'd1);
    tick();

    // Single SW drains on the next cycle
    step(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'h0, 3'b000);
    model_check();
    tick();
    idle();
    model_check();
    chk("sw_we", 64'(sb_if.mem_WE), 64'd1);
    chk("sw_a",  64'(sb_if.mem_A), 64'h100);
    chk("sw_wd", 64'(sb_if.mem_WD), 64'hDEAD_BEEF);
    chk("sw_ac", 64'(sb_if.mem_AddressingControl), 64'd2);
    tick();
    idle();
    chk("sw_empty", 64'(sb_if.empty), 64'd1);
    tick();

    // Five SBs while a non-overlapping load holds the port
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 32'h10 + i, 32'hA0 + i, 3'b000, 1'b1, 32'h200, 3'b000);
      model_check();
      if (i == 4) chk("fill_ready", 64'(sb_if.st_ready), 64'd0);
      chk("fill_we", 64'(sb_if.mem_WE), 64'd0);
      tick();
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h200, 3'b000);
    chk("fill_count", 64'(sb_if.count), 64'd4);
    tick();
    for (int i = 0; i < 4; i++) begin
      idle();
      model_check();
      chk("drain_a", 64'(sb_if.mem_A), 64'(32'h10 + i));
      tick();
    end

    // SH at 0x0FF covers 0x100, so LB 0x100 must wait one drain
    step(1'b0, 1'b1, 32'h0FF, 32'h1234, 3'b001, 1'b0, 32'h0, 3'b000);
    tick();
    step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h100, 3'b000);
    model_check();
    chk("sh_stall", 64'(sb_if.ld_stall), 64'd1);
    chk("sh_we",    64'(sb_if.mem_WE), 64'd1);
    tick();
    step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h100, 3'b000);
    model_check();
    chk("lb_stall", 64'(sb_if.ld_stall), 64'd0);
    chk("lb_a",     64'(sb_if.mem_A), 64'h100);
    tick();

    // SW at 0xFFFE wraps onto 0x0000..0x0001
    step(1'b0, 1'b1, 32'hFFFE, 32'h5555_AAAA, 3'b010, 1'b0, 32'h0, 3'b000);
    tick();
    step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h0002, 3'b100);
    model_check();
    chk("wrap_nostall", 64'(sb_if.ld_stall), 64'd0);
    tick();
    step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h0000, 3'b100);
    model_check();
    chk("wrap_stall", 64'(sb_if.ld_stall), 64'd1);
    tick();

    // Full buffer: store rejected while draining, accepted next cycle, then streaming
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'h20 + 4 * i, 32'hB0 + i, 3'b010, 1'b1, 32'h300, 3'b010);
      tick();
    end
    step(1'b0, 1'b1, 32'h60, 32'hC0, 3'b010, 1'b0, 32'h0, 3'b000);
    model_check();
    chk("full_ready", 64'(sb_if.st_ready), 64'd0);
    tick();
    step(1'b0, 1'b1, 32'h60, 32'hC0, 3'b010, 1'b0, 32'h0, 3'b000);
    model_check();
    chk("full_count3", 64'(sb_if.count), 64'd3);
    tick();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'h80 + 4 * i, 32'hD0 + i, 3'b010, 1'b0, 32'h0, 3'b000);
      model_check();
      tick();
    end

    // Reset wins over a concurrent store
    step(1'b1, 1'b1, 32'h90, 32'hE0, 3'b010, 1'b0, 32'h0, 3'b000);
    model_check();
    tick();
    idle();
    chk("rstmid_count", 64'(sb_if.count), 64'd0);
    chk("rstmid_empty", 64'(sb_if.empty), 64'd1);
    chk("rstmid_we",    64'(sb_if.mem_WE), 64'd0);
    tick();

    // Illegal store type is ignored
    step(1'b0, 1'b1, 32'h40, 32'hF0, 3'b000, 1'b1, 32'h500, 3'b000);
    tick();
    step(1'b0, 1'b1, 32'h44, 32'hF1, 3'b011, 1'b1, 32'h500, 3'b000);
    tick();
    step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h500, 3'b000);
    model_check();
    chk("bad_type_count", 64'(sb_if.count), 64'd1);
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      sa = bases[$urandom_range(0, 2)] + $urandom_range(0, 7);
      la = bases[$urandom_range(0, 2)] + $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) la = la ^ 32'h0004_0000;
      sf = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      lf = lds[$urandom_range(0, 4)];
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 6), sa, $urandom(), sf,
           ($urandom_range(0, 1) == 1), la, lf);
      model_check();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data and address width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 16, meaning the low address bits decoded by data memory.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning buffer entries (power of two, at least 2).
REQ-004 The block SHALL have these ports, one per line:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- st_valid  input  1  store request from the pipeline.
- st_addr  input  XLEN  store byte address.
- st_data  input  XLEN  store data, right-aligned.
- st_funct3  input  3  store type: 000 SB, 001 SH, 010 SW.
- st_ready  output  1  buffer can accept a store this cycle.
- ld_valid  input  1  load request from the pipeline.
- ld_addr  input  XLEN  load byte address.
- ld_funct3  input  3  load type: 000, 001, 010, 100, 101.
- ld_stall  output  1  load overlaps a buffered store; pipeline must hold and retry.
- mem_WE  output  1  write enable to data memory.
- mem_A  output  XLEN  data memory address.
- mem_WD  output  XLEN  data memory write data.
- mem_AddressingControl  output  3  funct3 to data memory.
- empty  output  1  no buffered stores.
- count  output  $clog2(DEPTH)+1  number of buffered stores.

Function
REQ-005 The block SHALL hold stores in a circular FIFO of DEPTH entries {addr, data, funct3} with head and tail pointers that wrap modulo DEPTH.
REQ-006 st_ready SHALL be 1 exactly when count < DEPTH, with no same-cycle pop bypass.
REQ-007 A store SHALL be enqueued at the tail on a posedge where st_valid=1, st_ready=1 and st_funct3 is 000, 001 or 010.
REQ-008 A store with any other st_funct3 SHALL be discarded with no state change.
REQ-009 Each byte range SHALL be [addr, addr+size-1] modulo 2^ADDRESS_WIDTH, with size 1 for x00, 2 for x01 and 4 for x10 of funct3[1:0].
REQ-010 ld_stall SHALL be combinational: ld_valid AND the load's byte range shares at least one byte with any valid entry.
REQ-011 A store enqueued on the same posedge as a load SHALL NOT be included in that load's overlap check.
REQ-012 Port arbitration: when ld_valid=1 and ld_stall=0, the block SHALL drive mem_A=ld_addr, mem_AddressingControl=ld_funct3, mem_WE=0 and mem_WD=0.
REQ-013 Otherwise, if count>0, the block SHALL drive the head entry with mem_A=addr, mem_WD=data, mem_AddressingControl=funct3 and mem_WE=1, and pop the head at the posedge (drain, one per cycle).
REQ-014 Otherwise the block SHALL drive mem_A=0, mem_WD=0, mem_AddressingControl=0 and mem_WE=0.
REQ-015 On a simultaneous enqueue and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-016 Stores SHALL drain in strict FIFO order with a minimum latency of 1 cycle from acceptance to mem_WE.
REQ-017 empty SHALL equal (count==0).
REQ-018 A stalled load SHALL never block draining, so no deadlock is possible.

Reset
REQ-019 On posedge with rst=1, the block SHALL set count=0, head=0 and tail=0, which gives empty=1, st_ready=1 and mem_WE=0; rst SHALL take priority over any enqueue or pop in the same cycle.
REQ-020 Entry storage SHALL need no reset, and buffered stores SHALL be lost on reset mid-operation.

Verification
REQ-021 The bench SHALL cover: after rst, SW 0x100 data 0xDEADBEEF with no load -> next cycle mem_WE=1, mem_A=0x100, mem_WD=0xDEADBEEF, mem_AddressingControl=010; following cycle empty=1.
REQ-022 The bench SHALL cover: 5 back-to-back SB with ld_valid held 1 to non-overlapping 0x200 -> st_ready=0 after 4 accepted, count=4, mem_WE=0 throughout; release ld_valid -> 4 writes in order, one per cycle.
REQ-023 The bench SHALL cover: buffered SH at 0x0FF, load LB at 0x100 -> ld_stall=1 and the head drains (mem_WE=1); next cycle ld_stall=0 and mem_A=0x100 with mem_WE=0.
REQ-024 The bench SHALL cover: buffered SW 0xFFFE (wraps to 0x0001), load LBU 0x0000 -> ld_stall=1; load LBU 0x0002 -> ld_stall=0.
REQ-025 The bench SHALL cover: full buffer with simultaneous drain and st_valid -> store rejected (st_ready=0); next cycle count=3, st_ready=1, accepted; tail pointer wraps correctly over 10 cycles of streaming.
REQ-026 The bench SHALL cover: rst asserted with count=3 plus a concurrent st_valid -> next cycle count=0, empty=1, mem_WE=0, no write issued; st_funct3=011 -> ignored, count unchanged.
